// File: rtl/pc_unit_ras_pkg.sv
// Shared types and constants for the program counter with return-address stack.
// Holds the next-PC select encoding, default reset/trap vectors and a width helper.
// Purely declarative; no logic lives here.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_HOLD,
        SEL_JUMP,
        SEL_RET,
        SEL_BRANCH,
        SEL_SEQ
    } pc_sel_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

    // Smallest r with 2**r >= value; used to size counters and pointers.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: push writes at the pointer, top is the entry below it.
// Push when full overwrites the oldest entry and pulses overflow; pop when empty pulses underflow.
// Push wins over pop if both are requested; pulses are registered and last one cycle.
module ras_stack
    import pc_pkg::*;
#(
    parameter int N         = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic                              pop,
    input  logic [N-1:0]                      push_data,
    output logic [N-1:0]                      top,
    output logic [clog2(RAS_DEPTH+1)-1:0]     count,
    output logic                              full,
    output logic                              empty,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int CW = clog2(RAS_DEPTH + 1);
    localparam int PW = clog2(RAS_DEPTH);

    logic [N-1:0]  mem [RAS_DEPTH];
    logic [PW-1:0] ptr;

    // The pointer always names the next free slot, so the top sits one below it
    // (modulo depth, since the depth is a power of two).
    assign top   = mem[ptr - PW'(1)];
    assign empty = (count == '0);
    assign full  = (count == CW'(RAS_DEPTH));

    // Entry storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

    // Pointer, occupancy and one-cycle error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (push) begin
                ptr <= ptr + PW'(1);
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
            end else if (pop) begin
                if (empty) begin
                    underflow <= 1'b1;
                end else begin
                    ptr   <= ptr - PW'(1);
                    count <= count - CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pc_unit_ras.sv
// Program counter with trap redirect, stall, jump/call, return and PC-relative branch.
// pc_out and epc are registered: control inputs sampled on an edge take effect one cycle later.
// Stall freezes PC and stack; only trap overrides it.
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int           N            = 32,
    parameter int           RAS_DEPTH    = 4,
    parameter int           INC          = 1,
    parameter logic [N-1:0] RESET_VECTOR = N'(DEF_RESET_VECTOR),
    parameter logic [N-1:0] TRAP_VECTOR  = N'(DEF_TRAP_VECTOR)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          trap,
    input  logic                          jump,
    input  logic                          call,
    input  logic                          ret,
    input  logic                          pc_src,
    input  logic [N-1:0]                  jump_address,
    input  logic [N-1:0]                  branch_offset,
    output logic [N-1:0]                  pc_out,
    output logic [N-1:0]                  epc,
    output logic [clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                          ras_empty,
    output logic                          ras_full,
    output logic                          ras_overflow,
    output logic                          ras_underflow
);

    pc_sel_e      sel;
    logic [N-1:0] pc_inc;
    logic [N-1:0] next_pc;
    logic [N-1:0] ras_top;
    logic         push;
    logic         pop;

    assign pc_inc = pc_out + N'(INC);

    // Priority decode: trap > stall > jump > ret > branch > sequential.
    always_comb begin
        sel = SEL_SEQ;
        if (trap) begin
            sel = SEL_TRAP;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (jump) begin
            sel = SEL_JUMP;
        end else if (ret) begin
            sel = SEL_RET;
        end else if (pc_src) begin
            sel = SEL_BRANCH;
        end
    end

    // A call only counts when it rides on a jump; ret under a jump is dropped.
    assign push = (sel == SEL_JUMP) && call;
    assign pop  = (sel == SEL_RET);

    // Next-PC mux; a return with nothing on the stack just falls through.
    always_comb begin
        next_pc = pc_inc;
        case (sel)
            SEL_TRAP:   next_pc = TRAP_VECTOR;
            SEL_HOLD:   next_pc = pc_out;
            SEL_JUMP:   next_pc = jump_address;
            SEL_RET:    next_pc = ras_empty ? pc_inc : ras_top;
            SEL_BRANCH: next_pc = pc_out + branch_offset;
            default:    next_pc = pc_inc;
        endcase
    end

    // PC and exception-PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out <= RESET_VECTOR;
            epc    <= '0;
        end else begin
            pc_out <= next_pc;
            if (sel == SEL_TRAP) begin
                epc <= pc_out;
            end
        end
    end

    ras_stack #(
        .N         (N),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

endmodule
